// File: rtl/gmem_rd_master.sv
// Read master: splits a request into bursts of up to 256 beats and buffers the returned data in a FIFO.
// Optional watchdog: define GMEM_RD_TIMEOUT_EN.
module gmem_rd_master #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int ID_W         = 4,
    parameter int FIFO_DEPTH_W = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_nbeats,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] m0_araddr,
    output logic [7:0]        m0_arlen,
    output logic              m0_arvalid,
    input  logic              m0_arready,
    output logic [ID_W-1:0]   m0_arid,
    input  logic [DATA_W-1:0] m0_rdata,
    input  logic              m0_rlast,
    input  logic              m0_rvalid,
    output logic              m0_rready,
    input  logic [ID_W-1:0]   m0_rid
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_W;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   next_addr;
    logic [16:0]         remaining;
    logic [7:0]          beat_cnt;

    logic [DATA_W:0]     fifo_mem [DEPTH];
    logic [FIFO_DEPTH_W-1:0] wr_ptr;
    logic [FIFO_DEPTH_W-1:0] rd_ptr;
    logic [FIFO_DEPTH_W:0]   fifo_cnt;
    logic                fifo_full;
    logic                fifo_empty;

    logic                ar_hs;
    logic                push;
    logic                pop;
    logic                beat_last;
    logic                req_last;
    logic                beat_err;
    logic [16:0]         burst_beats;
    logic [ADDR_W-1:0]   burst_bytes;

    function automatic logic [7:0] burst_len(input logic [16:0] beats);
        if (beats > 17'd256) return 8'hFF;
        return 8'(beats - 17'd1);
    endfunction

    always_comb begin
        fifo_full   = fifo_cnt[FIFO_DEPTH_W];
        fifo_empty  = (fifo_cnt == '0);
        req_ready   = (state == IDLE);
        m0_rready   = (state == DATA) && !fifo_full;
        rd_valid    = !fifo_empty;
        busy        = (state != IDLE) || !fifo_empty;
        m0_arid     = '0;
        ar_hs       = m0_arvalid && m0_arready;
        push        = m0_rvalid && m0_rready;
        pop         = rd_valid && rd_ready;
        burst_beats = {9'd0, m0_arlen} + 17'd1;
        burst_bytes = ADDR_W'(burst_beats * BYTES);
        // remaining already excludes the current burst once DATA is entered
        beat_last   = (beat_cnt == m0_arlen);
        req_last    = beat_last && (remaining == '0);
        beat_err    = (m0_rlast != beat_last) || (m0_rid != '0);
        rd_data     = fifo_mem[rd_ptr][DATA_W-1:0];
        rd_last     = fifo_mem[rd_ptr][DATA_W];
    end

`ifdef GMEM_RD_TIMEOUT_EN
    logic [9:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (nrst) begin
            state      <= IDLE;
            remaining  <= '0;
            next_addr  <= '0;
            beat_cnt   <= '0;
            m0_araddr  <= '0;
            m0_arlen   <= '0;
            m0_arvalid <= 1'b0;
            err        <= 1'b0;
`ifdef GMEM_RD_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        m0_araddr  <= req_addr;
                        remaining  <= {1'b0, req_nbeats} + 17'd1;
                        m0_arlen   <= burst_len({1'b0, req_nbeats} + 17'd1);
                        m0_arvalid <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        m0_arvalid <= 1'b0;
                        remaining  <= remaining - burst_beats;
                        next_addr  <= m0_araddr + burst_bytes;
                        beat_cnt   <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (push) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_err) err <= 1'b1;
                        // burst end follows the beat count, not m0_rlast
                        if (beat_last) begin
                            if (remaining != '0) begin
                                m0_araddr  <= next_addr;
                                m0_arlen   <= burst_len(remaining);
                                m0_arvalid <= 1'b1;
                                state      <= ADDR;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef GMEM_RD_TIMEOUT_EN
            if (state == IDLE || ar_hs || push) begin
                wd_cnt <= '0;
            end else if (wd_cnt == 10'h3FF) begin
                wd_cnt     <= '0;
                err        <= 1'b1;
                m0_arvalid <= 1'b0;
                state      <= IDLE;
            end else begin
                wd_cnt <= wd_cnt + 10'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {req_last, m0_rdata};
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_W'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_W'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + (FIFO_DEPTH_W+1)'(1);
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - (FIFO_DEPTH_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_gmem_rd_master.sv
// Scoreboard bench for gmem_rd_master: directed requests, memory-model slave, decoupled monitor.
module tb_gmem_rd_master;
    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_nbeats;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        err;
    logic [31:0] m0_araddr;
    logic [7:0]  m0_arlen;
    logic        m0_arvalid;
    logic        m0_arready;
    logic [3:0]  m0_arid;
    logic [63:0] m0_rdata;
    logic        m0_rlast;
    logic        m0_rvalid;
    logic        m0_rready;
    logic [3:0]  m0_rid;

    always #5 clk = ~clk;

    gmem_rd_master #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .FIFO_DEPTH_W(4)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_nbeats(req_nbeats),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .err(err),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_arid(m0_arid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready), .m0_rid(m0_rid)
    );

    typedef struct packed { logic last; logic [63:0] data; } beat_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;

    beat_t exp_q[$];
    ar_t   ar_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int r_count  = 0;
    int bad_rid_beat  = -1;
    int bad_last_beat = -1;
    logic ar_hold = 1'b0;
    logic rd_hold = 1'b0;
    logic rd_slow = 1'b0;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory-model slave: accepts AR, returns beats pat(addr + beat*8); drives rd_ready too.
    initial begin : slave
        int beat;
        int blen;
        int cyc;
        logic active;
        logic ar_fire;
        logic r_fire;
        logic rst_seen;
        logic [31:0] baddr;
        logic [31:0] ar_a;
        logic [7:0]  ar_l;
        beat = 0; blen = 0; cyc = 0; active = 1'b0; baddr = '0;
        m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rlast = 1'b0; m0_rid = '0;
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire  = m0_arvalid && m0_arready;
            r_fire   = m0_rvalid && m0_rready;
            rst_seen = nrst;
            ar_a     = m0_araddr;
            ar_l     = m0_arlen;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_seen) begin
                active = 1'b0;
            end else begin
                if (r_fire) begin
                    r_count++;
                    if (beat == blen) active = 1'b0;
                    else beat++;
                end
                if (ar_fire) begin
                    active = 1'b1;
                    baddr  = ar_a;
                    blen   = int'(ar_l);
                    beat   = 0;
                end
            end
            m0_arready = !ar_hold;
            rd_ready   = !rd_hold && (rd_slow ? ((cyc % 4) != 3) : 1'b1);
            m0_rvalid  = active;
            m0_rdata   = pat(baddr + 32'(beat) * 32'd8);
            m0_rlast   = active && (beat == blen || beat == bad_last_beat);
            m0_rid     = (active && beat == bad_rid_beat) ? 4'd1 : 4'd0;
        end
    end

    initial begin : monitor
        beat_t e;
        ar_t   a;
        forever begin
            @(negedge clk);
            if (!nrst && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got data %h last %b, none expected", rd_data, rd_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_last", rd_last, e.last);
                end
            end
            if (!nrst && m0_arvalid && m0_arready) begin
                if (ar_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ar_unexpected: got addr %h len %0d, none expected", m0_araddr, m0_arlen);
                end else begin
                    a = ar_q.pop_front();
                    chk("ar_addr", m0_araddr, a.addr);
                    chk("ar_len", m0_arlen, a.len);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [15:0] nb);
        logic ok;
        for (int i = 0; i <= int'(nb); i++)
            exp_q.push_back('{last: (i == int'(nb)), data: pat(a + 32'(i) * 32'd8)});
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_addr   = a;
        req_nbeats = nb;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("req_accept", ok, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("arvalid_next", m0_arvalid, 1);
    endtask

    task automatic wait_idle(input string nm);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && ar_q.size() == 0) begin done = 1'b1; break; end
        end
        chk(nm, done, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int base;
        logic ok;
        nrst = 1'b1; req_valid = 1'b0; req_addr = '0; req_nbeats = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", m0_arvalid, 0);
        chk("rst_rready", m0_rready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_araddr", m0_araddr, 0);
        chk("rst_arlen", m0_arlen, 0);
        chk("rst_arid", m0_arid, 0);
        @(posedge clk);
        #1 nrst = 1'b0;

        // Basic 4-beat request
        ar_q.push_back('{addr: 32'h1000_0000, len: 8'd3});
        do_req(32'h1000_0000, 16'd3);
        wait_idle("drain_4beat");
        chk("err_4beat", err, 0);

        // 300 beats split into 256 + 44, consumer throttled
        rd_slow = 1'b1;
        ar_q.push_back('{addr: 32'h1000_0000, len: 8'd255});
        ar_q.push_back('{addr: 32'h1000_0800, len: 8'd43});
        do_req(32'h1000_0000, 16'd299);
        wait_idle("drain_300beat");
        chk("err_300beat", err, 0);
        rd_slow = 1'b0;

        // Back-pressure: consumer stalls, FIFO fills to 16
        rd_hold = 1'b1;
        base = r_count;
        ar_q.push_back('{addr: 32'h1000_1000, len: 8'd31});
        do_req(32'h1000_1000, 16'd31);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("fill_beats", 64'(r_count - base), 16);
        chk("rready_full", m0_rready, 0);
        chk("busy_full", busy, 1);
        rd_hold = 1'b0;
        wait_idle("drain_stall");

        // Bad ID on beat 2
        bad_rid_beat = 2;
        ar_q.push_back('{addr: 32'h1000_2000, len: 8'd3});
        do_req(32'h1000_2000, 16'd3);
        wait_idle("drain_badid");
        chk("err_badid", err, 1);
        bad_rid_beat = -1;
        pulse_reset();
        chk("err_cleared", err, 0);

        // Early rlast on beat 1, then stickiness across a clean request
        bad_last_beat = 1;
        ar_q.push_back('{addr: 32'h1000_3000, len: 8'd3});
        do_req(32'h1000_3000, 16'd3);
        wait_idle("drain_badlast");
        chk("err_badlast", err, 1);
        bad_last_beat = -1;
        ar_q.push_back('{addr: 32'h1000_4000, len: 8'd1});
        do_req(32'h1000_4000, 16'd1);
        wait_idle("drain_sticky");
        chk("err_sticky", err, 1);
        pulse_reset();
        chk("err_cleared2", err, 0);

        // Reset in the middle of a 64-beat burst
        rd_hold = 1'b1;
        base = r_count;
        ar_q.push_back('{addr: 32'h2000_0000, len: 8'd63});
        do_req(32'h2000_0000, 16'd63);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (r_count - base >= 10) begin ok = 1'b1; break; end
        end
        chk("beats_before_reset", ok, 1);
        pulse_reset();
        exp_q.delete();
        rd_hold = 1'b0;
        chk("mid_req_ready", req_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_arvalid", m0_arvalid, 0);
        chk("mid_rready", m0_rready, 0);
        chk("mid_araddr", m0_araddr, 0);
        chk("mid_arlen", m0_arlen, 0);
        ar_q.push_back('{addr: 32'h2000_0100, len: 8'd1});
        do_req(32'h2000_0100, 16'd1);
        wait_idle("drain_after_reset");

        // AR never accepted
        ar_hold = 1'b1;
        ar_q.push_back('{addr: 32'h3000_0000, len: 8'd1});
        do_req(32'h3000_0000, 16'd1);
`ifdef GMEM_RD_TIMEOUT_EN
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; break; end
        end
        chk("wd_err", ok, 1);
        chk("wd_idle", req_ready, 1);
        chk("wd_arvalid", m0_arvalid, 0);
        ar_q.delete();
        exp_q.delete();
        ar_hold = 1'b0;
        pulse_reset();
        chk("wd_err_cleared", err, 0);
`else
        repeat (1100) @(posedge clk);
        @(negedge clk);
        chk("hold_arvalid", m0_arvalid, 1);
        chk("hold_araddr", m0_araddr, 32'h3000_0000);
        chk("hold_err", err, 0);
        chk("hold_not_idle", req_ready, 0);
        ar_hold = 1'b0;
        wait_idle("drain_hold");
        chk("hold_err_end", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
